// File: rtl/qs_isort.sv
// qs_isort: packet insertion sorter.
//
// Words of one packet (SOP..EOP) are inserted one per cycle into a register
// array that stays sorted by the direction latched on the SOP beat. Equal
// words keep their arrival order. Once the EOP beat is in, the array is
// streamed out through a registered valid/ready output stage. Words arriving
// after the array is full are dropped and flagged on the last output beat.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_vld     input beat valid
//   in_sop     first beat of packet
//   in_eop     last beat of packet
//   in_dir     sort direction, 0 ascending / 1 descending (SOP beat only)
//   in_dat     unsigned input word
//   in_rdy     input ready (low while draining)
//   out_rdy    downstream ready
//   out_vld_r  output beat valid
//   out_sop_r  output first beat
//   out_eop_r  output last beat
//   out_err_r  overflow flag, only on the last beat
//   out_dat_r  sorted output word
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an SOP beat; non-SOP beats are dropped
// FILL  | inserting beats of the current packet into the array
// DRAIN | streaming entries 0..cnt-1 out; input held off
module qs_isort #(
  parameter int W = 32,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic         in_sop,
  input  logic         in_eop,
  input  logic         in_dir,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  input  logic         out_rdy,
  output logic         out_vld_r,
  output logic         out_sop_r,
  output logic         out_eop_r,
  output logic         out_err_r,
  output logic [W-1:0] out_dat_r
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   arr_q   [N];
  logic [W-1:0]   arr_ins [N];
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  rd_idx_q;
  logic           dir_q;
  logic           err_q;

  logic           acc;
  logic           start;
  logic           full;
  logic           ins;
  logic           ovf;
  logic           load;
  logic           last_pop;
  logic           rd_last;
  logic [N-1:0]   gt;
  logic [W-1:0]   rd_word;

  assign in_rdy   = (state_q != DRAIN);
  assign acc      = in_vld && in_rdy;
  assign start    = acc && in_sop;
  assign full     = (cnt_q == CW'(N));
  assign ins      = acc && !in_sop && (state_q == FILL) && !full;
  assign ovf      = acc && !in_sop && (state_q == FILL) && full;
  assign load     = (state_q == DRAIN) && (!out_vld_r || out_rdy) && (rd_idx_q < cnt_q);
  assign last_pop = out_vld_r && out_rdy && out_eop_r;
  assign rd_last  = (rd_idx_q == (cnt_q - CW'(1)));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = in_eop ? DRAIN : FILL;
      FILL:    if (acc && in_eop) state_d = DRAIN;
      DRAIN:   if (last_pop && !load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // gt[i]: the new word belongs in front of occupied entry i. Because the
  // array is sorted these flags form a suffix of the occupied range, so each
  // slot either keeps its word, takes its left neighbour, or takes the new
  // word. The strict compare puts a new word behind any equal entries.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      gt[i] = (CW'(i) < cnt_q) &&
              (dir_q ? (in_dat > arr_q[i]) : (in_dat < arr_q[i]));
    end
    arr_ins[0] = (gt[0] || (cnt_q == '0)) ? in_dat : arr_q[0];
    for (int i = 1; i < N; i++) begin
      if (gt[i-1])
        arr_ins[i] = arr_q[i-1];
      else if (gt[i] || (CW'(i) == cnt_q))
        arr_ins[i] = in_dat;
      else
        arr_ins[i] = arr_q[i];
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_idx_q == CW'(i)) rd_word = arr_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) arr_q[i] <= '0;
      cnt_q     <= '0;
      rd_idx_q  <= '0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
      out_vld_r <= 1'b0;
      out_sop_r <= 1'b0;
      out_eop_r <= 1'b0;
      out_err_r <= 1'b0;
      out_dat_r <= '0;
    end else begin
      if (start) begin
        for (int i = 1; i < N; i++) arr_q[i] <= '0;
        arr_q[0] <= in_dat;
        cnt_q    <= CW'(1);
        rd_idx_q <= '0;
        dir_q    <= in_dir;
        err_q    <= 1'b0;
      end else if (ins) begin
        for (int i = 0; i < N; i++) arr_q[i] <= arr_ins[i];
        cnt_q <= cnt_q + CW'(1);
      end else if (ovf) begin
        err_q <= 1'b1;
      end

      if (load) begin
        out_vld_r <= 1'b1;
        out_dat_r <= rd_word;
        out_sop_r <= (rd_idx_q == '0);
        out_eop_r <= rd_last;
        out_err_r <= rd_last && err_q;
        rd_idx_q  <= rd_idx_q + CW'(1);
      end else if (out_vld_r && out_rdy) begin
        out_vld_r <= 1'b0;
        out_sop_r <= 1'b0;
        out_eop_r <= 1'b0;
        out_err_r <= 1'b0;
      end
    end
  end

endmodule
